// File: rtl/tdc_readout_arbiter.sv
// Round-robin readout arbiter: pulls one byte at a time from NCH TDC hit FIFOs
// and emits tagged {ch, seq, data} words over a valid/ready handshake.
//
// state | meaning
// IDLE  | no transaction in flight, waiting for an enabled pending channel
// RD    | read strobe to the granted channel's FIFO
// LAT   | FIFO data returns; output word captured on the exit edge
// OUT   | word presented, held until the sink accepts it
module tdc_readout_arbiter #(
    parameter int NCH = 4
) (
    input  logic             SYSCLK,
    input  logic             RESET_N,
    input  logic [NCH-1:0]   fifo_data_available,
    output logic [NCH-1:0]   read_fifo,
    input  logic [8*NCH-1:0] fifo_dout,
    input  logic [NCH-1:0]   enable_mask,
    output logic [15:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [15:0]      word_count
);

    localparam int IW = $clog2(NCH);

    typedef enum logic [1:0] {IDLE, RD, LAT, OUT} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] g_q, g_d;
    logic [IW-1:0] last_grant_q, last_grant_d;
    logic [4:0]    seq_q, seq_d;
    logic [15:0]   word_count_q, word_count_d;
    logic [15:0]   out_data_q, out_data_d;

    logic [NCH-1:0] req;
    logic           grant_found;
    logic [IW-1:0]  grant_idx;
    logic [7:0]     sel_byte;

    assign req = fifo_data_available & enable_mask;

    // Search starts one past the last grant so every requester is served in turn.
    always_comb begin
        logic [IW-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = IW'((int'(last_grant_q) + k) % NCH);
            if (!grant_found && req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < NCH; i++) begin
            if (g_q == IW'(i)) sel_byte = fifo_dout[8*i +: 8];
        end
    end

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            g_q          <= '0;
            last_grant_q <= IW'(NCH - 1);
            seq_q        <= '0;
            word_count_q <= '0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            g_q          <= g_d;
            last_grant_q <= last_grant_d;
            seq_q        <= seq_d;
            word_count_q <= word_count_d;
            out_data_q   <= out_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        g_d          = g_q;
        last_grant_d = last_grant_q;
        seq_d        = seq_q;
        word_count_d = word_count_q;
        out_data_d   = out_data_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    state_d      = RD;
                    g_d          = grant_idx;
                    last_grant_d = grant_idx;
                end
            end
            RD:  state_d = LAT;
            LAT: begin
                state_d    = OUT;
                out_data_d = {3'(g_q), seq_q, sel_byte};
            end
            OUT: begin
                if (out_ready) begin
                    seq_d = seq_q + 5'd1;
                    if (word_count_q != 16'hFFFF) word_count_d = word_count_q + 16'd1;
                    // Back-to-back grant skips IDLE to sustain one word per three cycles.
                    if (grant_found) begin
                        state_d      = RD;
                        g_d          = grant_idx;
                        last_grant_d = grant_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        read_fifo = '0;
        if (state_q == RD) read_fifo[g_q] = 1'b1;
        out_valid  = (state_q == OUT);
        busy       = (state_q != IDLE);
        out_data   = out_data_q;
        word_count = word_count_q;
    end

endmodule
